// File: rtl/cp_writeback_queue_if.sv
// cp_writeback_queue_if: issue/result/retire signal bundle for the coprocessor writeback queue
//  master: issue_valid, issue_rd, flush, cp_result, cp_result_valid, wb_pipe_busy out;
//          issue_ready, rf_we, rf_waddr, rf_wdata, busy_mask, pending_count, protocol_err in
//  slave:  the same signals in the opposite directions
interface cp_writeback_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int RADDR_W    = 5
);
  logic                     issue_valid;
  logic [RADDR_W-1:0]       issue_rd;
  logic                     issue_ready;
  logic                     flush;
  logic [DATA_WIDTH-1:0]    cp_result;
  logic                     cp_result_valid;
  logic                     wb_pipe_busy;
  logic                     rf_we;
  logic [RADDR_W-1:0]       rf_waddr;
  logic [DATA_WIDTH-1:0]    rf_wdata;
  logic [2**RADDR_W-1:0]    busy_mask;
  logic [$clog2(DEPTH):0]   pending_count;
  logic                     protocol_err;
  modport master (
    output issue_valid, issue_rd, flush, cp_result, cp_result_valid, wb_pipe_busy,
    input  issue_ready, rf_we, rf_waddr, rf_wdata, busy_mask, pending_count, protocol_err
  );
  modport slave (
    input  issue_valid, issue_rd, flush, cp_result, cp_result_valid, wb_pipe_busy,
    output issue_ready, rf_we, rf_waddr, rf_wdata, busy_mask, pending_count, protocol_err
  );
endinterface

// File: rtl/cp_writeback_queue.sv
// cp_writeback_queue: in-order pairing of coprocessor destinations with results, retired to the RF
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : slave side of cp_writeback_queue_if (issue, result, flush, RF write, scoreboard)
module cp_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int RADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cp_writeback_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NR = 2**RADDR_W;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW:0]   DMAX = (PW+1)'(2*DEPTH-1);
  logic [RADDR_W-1:0]    r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_filled;
  logic [PW-1:0]         r_head, r_fill, r_tail, r_drop;
  logic                  r_err;
  logic [PW-1:0]         w_count, w_fill_n, w_squash, w_tail_f, w_drop_n;
  logic [PW:0]           w_drop_sum;
  logic [AW-1:0]         w_hidx;
  logic                  w_full, w_head_rdy, w_pop, w_we, w_issue;
  logic                  w_drop_res, w_fill_res, w_unmatched;
  logic [NR-1:0]         w_mask;
  assign w_count    = r_tail - r_head;
  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign w_full     = (r_tail[AW] != r_head[AW]) && (r_tail[AW-1:0] == r_head[AW-1:0]);
  assign w_hidx     = r_head[AW-1:0];
  assign w_head_rdy = (r_head != r_tail) && r_filled[w_hidx];
  assign w_we       = w_head_rdy && (r_rd[w_hidx] != '0) && !bus.wb_pipe_busy;
  // x0 results are discarded at the head regardless of port availability.
  assign w_pop      = w_head_rdy && ((r_rd[w_hidx] == '0) || !bus.wb_pipe_busy);
  assign w_issue    = bus.issue_valid && !w_full;
  assign w_drop_res  = bus.cp_result_valid && (r_drop != '0);
  assign w_fill_res  = bus.cp_result_valid && (r_drop == '0) && (r_fill != r_tail);
  assign w_unmatched = bus.cp_result_valid && (r_drop == '0) && (r_fill == r_tail);
  // Result fill happens before flush truncation, so the squash count excludes the entry just filled.
  assign w_fill_n   = w_fill_res ? r_fill + ONE : r_fill;
  assign w_squash   = bus.flush ? r_tail - w_fill_n : '0;
  assign w_tail_f   = bus.flush ? w_fill_n : r_tail;
  assign w_drop_sum = {1'b0, r_drop} + {1'b0, w_squash} - (PW+1)'(w_drop_res);
  assign w_drop_n   = (w_drop_sum > DMAX) ? DMAX[PW-1:0] : w_drop_sum[PW-1:0];
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, AW'(i) - w_hidx} < w_count) w_mask[r_rd[i]] = 1'b1;
    w_mask[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_filled <= '0;
      r_head   <= '0;
      r_fill   <= '0;
      r_tail   <= '0;
      r_drop   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_pop) r_head <= r_head + ONE;
      if (w_fill_res) begin
        r_data[r_fill[AW-1:0]]   <= bus.cp_result;
        r_filled[r_fill[AW-1:0]] <= 1'b1;
      end
      if (w_issue) begin
        r_rd[w_tail_f[AW-1:0]]     <= bus.issue_rd;
        r_filled[w_tail_f[AW-1:0]] <= 1'b0;
      end
      r_fill <= w_fill_n;
      r_tail <= w_issue ? w_tail_f + ONE : w_tail_f;
      r_drop <= w_drop_n;
      if (w_unmatched || (bus.issue_valid && w_full)) r_err <= 1'b1;
    end
  end
  assign bus.issue_ready   = !w_full;
  assign bus.rf_we         = w_we;
  assign bus.rf_waddr      = w_we ? r_rd[w_hidx] : '0;
  assign bus.rf_wdata      = w_we ? r_data[w_hidx] : '0;
  assign bus.busy_mask     = w_mask;
  assign bus.pending_count = w_count;
  assign bus.protocol_err  = r_err;
endmodule

// File: tb/tb_cp_writeback_queue.sv
// tb_cp_writeback_queue: directed checks of issue, retire, scoreboard, flush and error behaviour
module tb_cp_writeback_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  cp_writeback_queue_if #(.DATA_WIDTH(32), .DEPTH(4), .RADDR_W(5)) wb ();
  cp_writeback_queue #(.DATA_WIDTH(32), .DEPTH(4), .RADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(wb));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    wb.issue_valid = 1'b0;
    wb.flush = 1'b0;
    wb.cp_result_valid = 1'b0;
    #1;
  endtask
  task automatic issue(input logic [4:0] rd);
    wb.issue_valid = 1'b1;
    wb.issue_rd = rd;
    cyc();
  endtask
  task automatic result(input logic [31:0] d);
    wb.cp_result_valid = 1'b1;
    wb.cp_result = d;
    cyc();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pending", 64'(wb.pending_count), 0);
    chk("rst_err", 64'(wb.protocol_err), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask
  initial begin
    wb.issue_valid = 1'b0;
    wb.issue_rd = '0;
    wb.flush = 1'b0;
    wb.cp_result = '0;
    wb.cp_result_valid = 1'b0;
    wb.wb_pipe_busy = 1'b0;
    #2;
    chk("reset_rf_we", 64'(wb.rf_we), 0);
    chk("reset_waddr", 64'(wb.rf_waddr), 0);
    chk("reset_wdata", 64'(wb.rf_wdata), 0);
    chk("reset_mask", 64'(wb.busy_mask), 0);
    chk("reset_pending", 64'(wb.pending_count), 0);
    chk("reset_ready", 64'(wb.issue_ready), 1);
    chk("reset_err", 64'(wb.protocol_err), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    // single issue then result three cycles later
    issue(5);
    chk("t1_mask", 64'(wb.busy_mask), 64'h20);
    chk("t1_pending", 64'(wb.pending_count), 1);
    chk("t1_we_early", 64'(wb.rf_we), 0);
    cyc();
    cyc();
    result(32'h1234);
    chk("t1_we", 64'(wb.rf_we), 1);
    chk("t1_waddr", 64'(wb.rf_waddr), 5);
    chk("t1_wdata", 64'(wb.rf_wdata), 64'h1234);
    chk("t1_mask_retiring", 64'(wb.busy_mask), 64'h20);
    cyc();
    chk("t1_mask_after", 64'(wb.busy_mask), 0);
    chk("t1_pending_after", 64'(wb.pending_count), 0);
    chk("t1_we_after", 64'(wb.rf_we), 0);
    // fill to capacity, overflow issue, in-order retire
    issue(3);
    issue(7);
    issue(9);
    issue(11);
    chk("t2_ready", 64'(wb.issue_ready), 0);
    chk("t2_pending", 64'(wb.pending_count), 4);
    chk("t2_mask", 64'(wb.busy_mask), 64'hA88);
    chk("t2_err_before", 64'(wb.protocol_err), 0);
    issue(13);
    chk("t2_err", 64'(wb.protocol_err), 1);
    chk("t2_pending_full", 64'(wb.pending_count), 4);
    chk("t2_mask_full", 64'(wb.busy_mask), 64'hA88);
    begin
      logic [4:0] rds [4] = '{5'd3, 5'd7, 5'd9, 5'd11};
      logic [31:0] ds [4] = '{32'h30, 32'h70, 32'h90, 32'hB0};
      for (int k = 0; k < 4; k++) begin
        result(ds[k]);
        chk("t2_we", 64'(wb.rf_we), 1);
        chk("t2_waddr", 64'(wb.rf_waddr), 64'(rds[k]));
        chk("t2_wdata", 64'(wb.rf_wdata), 64'(ds[k]));
      end
    end
    cyc();
    chk("t2_empty", 64'(wb.pending_count), 0);
    chk("t2_ready_after", 64'(wb.issue_ready), 1);
    // write port held by the pipeline
    do_reset();
    issue(12);
    wb.wb_pipe_busy = 1'b1;
    result(32'h55);
    for (int k = 0; k < 4; k++) begin
      chk("t3_we_blocked", 64'(wb.rf_we), 0);
      chk("t3_mask_held", 64'(wb.busy_mask), 64'h1000);
      cyc();
    end
    wb.wb_pipe_busy = 1'b0;
    #1;
    chk("t3_we", 64'(wb.rf_we), 1);
    chk("t3_waddr", 64'(wb.rf_waddr), 12);
    chk("t3_wdata", 64'(wb.rf_wdata), 64'h55);
    cyc();
    chk("t3_mask_after", 64'(wb.busy_mask), 0);
    // x0 destination never written, never shown busy
    do_reset();
    issue(0);
    chk("t4_mask_x0", 64'(wb.busy_mask), 0);
    issue(6);
    chk("t4_mask", 64'(wb.busy_mask), 64'h40);
    result(32'hAA);
    chk("t4_we_x0", 64'(wb.rf_we), 0);
    result(32'h66);
    chk("t4_we", 64'(wb.rf_we), 1);
    chk("t4_waddr", 64'(wb.rf_waddr), 6);
    chk("t4_wdata", 64'(wb.rf_wdata), 64'h66);
    cyc();
    chk("t4_pending", 64'(wb.pending_count), 0);
    // flush keeps filled head, drops results for squashed entries
    do_reset();
    issue(2);
    issue(4);
    issue(8);
    wb.wb_pipe_busy = 1'b1;
    result(32'h22);
    wb.flush = 1'b1;
    cyc();
    chk("t5_pending", 64'(wb.pending_count), 1);
    chk("t5_mask", 64'(wb.busy_mask), 64'h4);
    wb.wb_pipe_busy = 1'b0;
    #1;
    chk("t5_we", 64'(wb.rf_we), 1);
    chk("t5_waddr", 64'(wb.rf_waddr), 2);
    cyc();
    chk("t5_pending_after", 64'(wb.pending_count), 0);
    result(32'h44);
    chk("t5_drop1_we", 64'(wb.rf_we), 0);
    chk("t5_drop1_err", 64'(wb.protocol_err), 0);
    result(32'h88);
    chk("t5_drop2_we", 64'(wb.rf_we), 0);
    chk("t5_drop2_err", 64'(wb.protocol_err), 0);
    result(32'h99);
    chk("t5_unmatched_err", 64'(wb.protocol_err), 1);
    // flush + result + issue in the same cycle
    do_reset();
    issue(1);
    issue(14);
    wb.flush = 1'b1;
    wb.cp_result_valid = 1'b1;
    wb.cp_result = 32'h11;
    issue(10);
    chk("t6_we", 64'(wb.rf_we), 1);
    chk("t6_waddr", 64'(wb.rf_waddr), 1);
    chk("t6_wdata", 64'(wb.rf_wdata), 64'h11);
    chk("t6_pending", 64'(wb.pending_count), 2);
    chk("t6_mask", 64'(wb.busy_mask), 64'h402);
    cyc();
    chk("t6_pending2", 64'(wb.pending_count), 1);
    chk("t6_mask2", 64'(wb.busy_mask), 64'h400);
    result(32'hDEAD);
    chk("t6_drop_we", 64'(wb.rf_we), 0);
    result(32'hBEEF);
    chk("t6_we10", 64'(wb.rf_we), 1);
    chk("t6_waddr10", 64'(wb.rf_waddr), 10);
    chk("t6_wdata10", 64'(wb.rf_wdata), 64'hBEEF);
    cyc();
    chk("t6_empty", 64'(wb.pending_count), 0);
    chk("t6_err", 64'(wb.protocol_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
